rsp_s2_dma_cnt: RTL and testbench

Beat/address generator for the RSP stage-2 DMA. It consumes the `update` and `resume` pulses from the DMA control FSM and issues one read request per beat. It returns `pcnt_finish` at each packet (segment) boundary and `ccnt_finish` when the whole transfer is complete. It sits between the DMA control FSM and the memory read port.

---
 rtl/rsp_s2_dma_pkg.sv | 18 +
 rtl/rsp_s2_dma_beat_cnt.sv | 46 ++++
 rtl/rsp_s2_dma_cnt.sv | 176 +++++++++++++++++
 tb/tb_rsp_s2_dma_cnt.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsp_s2_dma_pkg.sv
// ============================================================================
//  rsp_s2_dma_pkg
//  Shared state encoding and defaults for the RSP stage-2 DMA blocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rsp_s2_dma_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam int BEAT_BYTES_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/rsp_s2_dma_beat_cnt.sv
// ============================================================================
//  rsp_s2_dma_beat_cnt
//  Load/clear/increment beat counter with a latched limit.
//  Flags when the next count equals that limit.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rsp_s2_dma_beat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_limit,
   input  logic             clr,
   input  logic             inc,
   output logic             nxt_hit
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_limit;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // A zero limit means "no limit": it never produces a hit.
   assign nxt_hit = (r_limit != '0) && (w_cnt_inc == r_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_limit <= '0;
      end else if (load) begin
         r_cnt   <= '0;
         r_limit <= load_limit;
      end else if (clr) begin
         r_cnt   <= '0;
      end else if (inc) begin
         r_cnt   <= w_cnt_inc;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rsp_s2_dma_cnt.sv
// ============================================================================
//  rsp_s2_dma_cnt
//  Beat/address generator for the RSP stage-2 DMA read port.
//  Define RSP_S2_DMA_CNT_ERR_EN to add the sticky protocol-error output err.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rsp_s2_dma_cnt
   import rsp_s2_dma_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 16,
   parameter int BEAT_BYTES = BEAT_BYTES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              update,
   input  logic              resume,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [CNT_W-1:0]  cfg_pkt_len,
   input  logic [CNT_W-1:0]  cfg_total_len,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   output logic              pcnt_finish,
   output logic              ccnt_finish,
   output logic              busy
`ifdef RSP_S2_DMA_CNT_ERR_EN
   ,
   output logic              err
`endif
);

   localparam logic [ADDR_W-1:0] c_BEAT_INC = ADDR_W'(BEAT_BYTES);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              r_rd_req;
   logic              r_pfin;
   logic              r_cfin;
   logic              r_busy;
   logic              w_rd_req_nxt;
   logic              w_pfin_nxt;
   logic              w_cfin_nxt;
   logic              w_busy_nxt;

   logic              w_zero_len;
   logic              w_acc;
   logic              w_p_hit;
   logic              w_c_hit;
   logic              w_p_clr;

   assign w_zero_len = (cfg_total_len == '0);

   // update overrides everything, so an ack in the same cycle is discarded.
   assign w_acc   = (r_state == ISSUE) && rd_ack && !update;
   assign w_p_clr = w_acc && w_p_hit && !w_c_hit;

   rsp_s2_dma_beat_cnt #(
      .CNT_W      (CNT_W)
   ) u_pcnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (update),
      .load_limit (cfg_pkt_len),
      .clr        (w_p_clr),
      .inc        (w_acc),
      .nxt_hit    (w_p_hit)
   );

   rsp_s2_dma_beat_cnt #(
      .CNT_W      (CNT_W)
   ) u_ccnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (update),
      .load_limit (cfg_total_len),
      .clr        (1'b0),
      .inc        (w_acc),
      .nxt_hit    (w_c_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_rd_req <= 1'b0;
         r_pfin   <= 1'b0;
         r_cfin   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_rd_req <= w_rd_req_nxt;
         r_pfin   <= w_pfin_nxt;
         r_cfin   <= w_cfin_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (update) begin
         w_state_nxt = w_zero_len ? IDLE : ISSUE;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            ISSUE: begin
               if (rd_ack) begin
                  if (w_c_hit) begin
                     w_state_nxt = IDLE;
                  end else if (w_p_hit) begin
                     w_state_nxt = HOLD;
                  end
               end
            end
            HOLD: begin
               if (resume) begin
                  w_state_nxt = ISSUE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Outputs are registered copies of next-cycle values, so the request
   // and busy flags always agree with the state they accompany.
   always_comb begin
      w_rd_req_nxt = (w_state_nxt == ISSUE);
      w_busy_nxt   = (w_state_nxt != IDLE);
      w_pfin_nxt   = w_acc && w_p_hit;
      w_cfin_nxt   = (update && w_zero_len) || (w_acc && w_c_hit);
      w_addr_nxt   = r_addr;
      if (update) begin
         w_addr_nxt = cfg_base_addr;
      end else if (w_acc) begin
         w_addr_nxt = r_addr + c_BEAT_INC;
      end
   end

   assign rd_req      = r_rd_req;
   assign rd_addr     = r_addr;
   assign pcnt_finish = r_pfin;
   assign ccnt_finish = r_cfin;
   assign busy        = r_busy;

`ifdef RSP_S2_DMA_CNT_ERR_EN
   logic r_err;
   logic w_err_set;

   assign w_err_set = (update && (r_state != IDLE))
                    || (resume && (r_state != HOLD))
                    || (rd_ack && !r_rd_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rsp_s2_dma_cnt.sv
// ============================================================================
//  tb_rsp_s2_dma_cnt
//  Randomized scoreboard bench for rsp_s2_dma_cnt.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rsp_s2_dma_cnt;

   localparam int ADDR_W = 32;
   localparam int CNT_W  = 16;
   localparam int BEAT   = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              update = 1'b0;
   logic              resume = 1'b0;
   logic [ADDR_W-1:0] cfg_base_addr = '0;
   logic [CNT_W-1:0]  cfg_pkt_len = '0;
   logic [CNT_W-1:0]  cfg_total_len = '0;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack = 1'b0;
   logic              pcnt_finish;
   logic              ccnt_finish;
   logic              busy;
`ifdef RSP_S2_DMA_CNT_ERR_EN
   logic              err;
`endif

   rsp_s2_dma_cnt #(
      .ADDR_W        (ADDR_W),
      .CNT_W         (CNT_W),
      .BEAT_BYTES    (BEAT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .update        (update),
      .resume        (resume),
      .cfg_base_addr (cfg_base_addr),
      .cfg_pkt_len   (cfg_pkt_len),
      .cfg_total_len (cfg_total_len),
      .rd_req        (rd_req),
      .rd_addr       (rd_addr),
      .rd_ack        (rd_ack),
      .pcnt_finish   (pcnt_finish),
      .ccnt_finish   (ccnt_finish),
      .busy          (busy)
`ifdef RSP_S2_DMA_CNT_ERR_EN
      ,
      .err           (err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ack_mode = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] exp_addr[$];
   logic [1:0]        exp_evt[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: beat i (1-based) goes to base+(i-1)*BEAT; a packet ends
   // every pkt beats, the transfer ends at beat total.
   function automatic void model_load(input logic [31:0] base, input logic [15:0] pkt,
                                      input logic [15:0] tot);
      logic pf;
      logic cf;
      exp_addr.delete();
      exp_evt.delete();
      if (tot == 0) exp_evt.push_back(2'b01);
      for (int i = 1; i <= int'(tot); i++) begin
         exp_addr.push_back(base + 32'((i - 1) * BEAT));
         pf = (pkt != 0) && ((i % int'(pkt)) == 0);
         cf = (i == int'(tot));
         if (pf || cf) exp_evt.push_back({pf, cf});
      end
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ack_mode)
            0:       rd_ack = rd_req;
            1:       rd_ack = rd_req & cyc[0];
            default: rd_ack = rd_req & 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops expected beats and finish events as the DUT shows them.
   initial begin
      logic       prev_acc;
      logic       prev_upd;
      logic       prev_req;
      logic [31:0] prev_addr;
      logic [1:0] e;
      prev_acc = 0; prev_upd = 0; prev_req = 0; prev_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("pulse_in_reset", {pcnt_finish, ccnt_finish}, 2'b00);
            prev_acc = 0; prev_upd = 0; prev_req = 0;
         end else begin
            if (pcnt_finish || ccnt_finish) begin
               chk("fin_latency", prev_acc | prev_upd, 1);
               chk("fin_req_low", rd_req, 0);
               chk("fin_expected", exp_evt.size() > 0, 1);
               if (exp_evt.size() > 0) begin
                  e = exp_evt.pop_front();
                  chk("fin_kind", {pcnt_finish, ccnt_finish}, e);
                  if (e[0]) chk("beats_left", exp_addr.size(), 0);
               end
            end
            if (rd_req && rd_ack && !update) begin
               chk("beat_expected", exp_addr.size() > 0, 1);
               if (exp_addr.size() > 0) chk("beat_addr", rd_addr, exp_addr.pop_front());
            end
            if (prev_req && !prev_acc && !prev_upd && rd_req)
               chk("addr_stable", rd_addr, prev_addr);
            prev_acc  = rd_req && rd_ack && !update;
            prev_upd  = update;
            prev_req  = rd_req;
            prev_addr = rd_addr;
         end
      end
   end

   task automatic do_update(input logic [31:0] base, input logic [15:0] pkt,
                            input logic [15:0] tot);
      @(posedge clk);
      #1;
      cfg_base_addr = base;
      cfg_pkt_len   = pkt;
      cfg_total_len = tot;
      update        = 1'b1;
      model_load(base, pkt, tot);
      @(posedge clk);
      #1;
      update = 1'b0;
      chk("upd_req", rd_req, tot != 0);
      chk("upd_busy", busy, tot != 0);
      if (tot != 0) chk("upd_addr", rd_addr, base);
   endtask

   task automatic wait_pulse(output logic [1:0] kind, input int budget);
      kind = 2'b00;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (pcnt_finish || ccnt_finish) begin
            kind = {pcnt_finish, ccnt_finish};
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL pulse_timeout: no finish pulse within %0d cycles", budget);
   endtask

   task automatic do_resume(input logic exp_req);
      @(posedge clk);
      #1;
      resume = 1'b1;
      @(posedge clk);
      #1;
      resume = 1'b0;
      chk("resume_req", rd_req, exp_req);
   endtask

   initial begin
      logic [1:0] k;
      logic [31:0] b;
      logic [15:0] p;
      logic [15:0] t;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", rd_req, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_pfin", pcnt_finish, 0);
      chk("rst_cfin", ccnt_finish, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);

      // Two packets of four beats, always acked.
      ack_mode = 0;
      do_update(32'h1000, 16'd4, 16'd8);
      wait_pulse(k, 40);
      chk("pkt1_kind", k, 2'b10);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      chk("hold_req", rd_req, 0);
      chk("hold_busy", busy, 1);
      do_resume(1'b1);
      wait_pulse(k, 40);
      chk("pkt2_kind", k, 2'b11);
      chk("done_busy", busy, 0);

      // Empty transfer.
      do_update(32'h3000, 16'd3, 16'd0);
      wait_pulse(k, 3);
      chk("zero_kind", k, 2'b01);

      // No packet pauses, ack every other cycle.
      ack_mode = 1;
      do_update(32'h4000, 16'd0, 16'd5);
      wait_pulse(k, 40);
      chk("nopkt_kind", k, 2'b01);

      // Address wrap.
      ack_mode = 0;
      do_update(32'hFFFF_FFF0, 16'd0, 16'd2);
      wait_pulse(k, 10);
      chk("wrap_kind", k, 2'b01);

      // Abort from HOLD with a new config; counters must restart.
      do_update(32'h5000, 16'd2, 16'd10);
      wait_pulse(k, 20);
      chk("abort_hold_kind", k, 2'b10);
      do_update(32'h2000, 16'd3, 16'd6);
      wait_pulse(k, 20);
      chk("restart_p_kind", k, 2'b10);
      do_resume(1'b1);
      wait_pulse(k, 20);
      chk("restart_c_kind", k, 2'b11);

      // Randomized transfers with random acks.
      ack_mode = 2;
      for (int n = 0; n < 25; n++) begin
         b = $urandom;
         p = 16'($urandom_range(0, 5));
         t = 16'($urandom_range(0, 12));
         do_update(b, p, t);
         for (int s = 0; s < 20; s++) begin
            wait_pulse(k, 300);
            if (k[0] || (k == 2'b00)) break;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_resume(1'b1);
         end
      end

      // Reset in the middle of a transfer.
      ack_mode = 0;
      do_update(32'h8000, 16'd0, 16'd10);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_addr.delete();
      exp_evt.delete();
      #1;
      chk("mid_rst_req", rd_req, 0);
      chk("mid_rst_addr", rd_addr, 0);
      chk("mid_rst_pfin", pcnt_finish, 0);
      chk("mid_rst_cfin", ccnt_finish, 0);
      chk("mid_rst_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_req", rd_req, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_fin", {pcnt_finish, ccnt_finish}, 2'b00);
`ifdef RSP_S2_DMA_CNT_ERR_EN
      chk("post_rst_err", err, 0);
`endif

      // resume while IDLE is ignored.
      do_resume(1'b0);
      chk("idle_resume_busy", busy, 0);
`ifdef RSP_S2_DMA_CNT_ERR_EN
      chk("idle_resume_err", err, 1);
`endif
      repeat (2) @(negedge clk);
      chk("final_idle_req", rd_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
